// File: rtl/ascon_round_sequencer.sv
// ASCON-128 encryption round sequencer: owns the round index and every load/XOR/valid strobe for the datapath.
// Block handshake in WAIT_AD/WAIT_PT only; AD phase exists only when ASCON_AD_EN is defined.
module ascon_round_sequencer (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       ad_en_i,
  input  logic       blk_valid_i,
  input  logic       blk_last_i,
  output logic       blk_ready_o,
  output logic [3:0] round_o,
  output logic       perm_en_o,
  output logic       load_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_data_o,
  output logic       xor_dom_sep_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_WAIT_AD,
    ST_PERM_AD,
    ST_WAIT_PT,
    ST_PERM_PT,
    ST_FINAL,
    ST_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ad_flag_q, ad_flag_d;
  logic       last_round;

`ifdef ASCON_AD_EN
  logic       last_q, last_d;

  // Last-AD flag is captured at the handshake and consumed on the final PERM_AD round.
  always_comb begin
    last_d = last_q;
    if ((state_q == ST_WAIT_AD) && blk_valid_i) begin
      last_d = blk_last_i;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic       ad_en_unused;
  assign ad_en_unused = ad_en_i;
`endif

  assign last_round = (cnt_q == 4'd11);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ad_flag_d       = ad_flag_q;
    blk_ready_o     = 1'b0;
    perm_en_o       = 1'b0;
    load_o          = 1'b0;
    xor_key_begin_o = 1'b0;
    xor_key_end_o   = 1'b0;
    xor_data_o      = 1'b0;
    xor_dom_sep_o   = 1'b0;
    cipher_valid_o  = 1'b0;
    tag_valid_o     = 1'b0;
    done_o          = 1'b0;
    busy_o          = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
`ifdef ASCON_AD_EN
          ad_flag_d = ad_en_i;
`else
          ad_flag_d = 1'b0;
`endif
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        load_o  = 1'b1;
        cnt_d   = 4'd0;
        state_d = ST_INIT;
      end

      ST_INIT: begin
        perm_en_o = 1'b1;
        if (last_round) begin
          xor_key_end_o = 1'b1;
          if (ad_flag_q) begin
            state_d = ST_WAIT_AD;
          end else begin
            xor_dom_sep_o = 1'b1;
            state_d       = ST_WAIT_PT;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

`ifdef ASCON_AD_EN
      ST_WAIT_AD: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          xor_data_o = 1'b1;
          cnt_d      = 4'd6;
          state_d    = ST_PERM_AD;
        end
      end

      ST_PERM_AD: begin
        perm_en_o = 1'b1;
        if (last_round) begin
          if (last_q) begin
            xor_dom_sep_o = 1'b1;
            state_d       = ST_WAIT_PT;
          end else begin
            state_d = ST_WAIT_AD;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif

      ST_WAIT_PT: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          xor_data_o     = 1'b1;
          cipher_valid_o = 1'b1;
          if (blk_last_i) begin
            xor_key_begin_o = 1'b1;
            cnt_d           = 4'd0;
            state_d         = ST_FINAL;
          end else begin
            cnt_d   = 4'd6;
            state_d = ST_PERM_PT;
          end
        end
      end

      ST_PERM_PT: begin
        perm_en_o = 1'b1;
        if (last_round) begin
          state_d = ST_WAIT_PT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_FINAL: begin
        perm_en_o = 1'b1;
        if (last_round) begin
          xor_key_end_o = 1'b1;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Constant generator sees 0 whenever no round is being applied.
    round_o = perm_en_o ? cnt_q : 4'd0;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      ad_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ad_flag_q <= ad_flag_d;
    end
  end

endmodule

// File: doc/ascon_round_sequencer.md
# ascon_round_sequencer

Control FSM for the ASCON-128 encryption datapath. It sequences the permutation rounds, p12 for initialization and finalization and p6 for associated data and plaintext blocks, and owns the 4-bit round index. It generates every load, XOR and valid strobe the datapath needs, and sits between the block-level handshake and the permutation/state register. Datapath registers, constants and key/nonce storage are outside this block.

## Interface
- No parameters.
- One clock; reset is asynchronous and active-low. The ports are `clock_i` and `resetb_i`.
- `clock_i` in 1: rising-edge clock.
- `resetb_i` in 1: async active-low reset.
- `start_i` in 1: begin one encryption; sampled in IDLE only.
- `ad_en_i` in 1: the message carries associated data; sampled with `start_i`.
- `blk_valid_i` in 1: input block available.
- `blk_last_i` in 1: current input block is the last of its phase; qualified by `blk_valid_i`.
- `blk_ready_o` out 1: block accepted this cycle if `blk_valid_i`=1.
- `round_o` out 4: round index fed to the constant generator, 0..11.
- `perm_en_o` out 1: the state register applies one round this cycle.
- `load_o` out 1: load IV‖K‖N into the state.
- `xor_key_begin_o` out 1: XOR 0‖K‖0 before the finalization p12.
- `xor_key_end_o` out 1: XOR the key into the state after the last round of init or final.
- `xor_data_o` out 1: XOR the input block into the state rate.
- `xor_dom_sep_o` out 1: XOR the domain-separation bit.
- `cipher_valid_o` out 1: ciphertext block valid.
- `tag_valid_o` out 1: tag valid.
- `busy_o` out 1: FSM not in IDLE.
- `done_o` out 1: one-cycle end-of-encryption pulse.

## Operation
- **States:** IDLE, LOAD, INIT, WAIT_AD, PERM_AD, WAIT_PT, PERM_PT, FINAL, DONE.
- **Reset:** the state is IDLE, the round counter and ad flag are 0, and all outputs are 0.
- **Handshake:** `hs` = `blk_valid_i` & `blk_ready_o`. `blk_ready_o`=1 only in WAIT_AD and WAIT_PT.
- **IDLE:**
  - On `start_i`=1: latch `ad_en_i` and go to LOAD.
  - Without `start_i`: stay in IDLE with all outputs 0.
- **LOAD:**
  - Outputs: `load_o`=1 for 1 cycle.
  - Next: INIT with the counter set to 0.
- **INIT:**
  - `perm_en_o`=1 and `round_o`=counter, counting 0→11.
  - Round 11 cycle: `xor_key_end_o`=1.
  - Exit with ad flag set: WAIT_AD.
  - Exit with ad flag clear: `xor_dom_sep_o`=1 on the round-11 cycle, then WAIT_PT.
- **WAIT_AD:**
  - On `hs`: `xor_data_o`=1; register `blk_last_i`; set the counter to 6; go to PERM_AD.
- **PERM_AD:**
  - `perm_en_o`=1 and `round_o` counts 6→11.
  - On round 11, if the registered last flag is set: `xor_dom_sep_o`=1, then WAIT_PT.
  - Otherwise: WAIT_AD.
- **WAIT_PT:**
  - On `hs`: `xor_data_o`=1 and `cipher_valid_o`=1 in the same cycle.
  - If `blk_last_i`=1: `xor_key_begin_o`=1, counter set to 0, go to FINAL.
  - Else: counter set to 6, go to PERM_PT.
- **PERM_PT:**
  - `perm_en_o`=1 and `round_o` counts 6→11, then WAIT_PT.
- **FINAL:**
  - `perm_en_o`=1 and `round_o` counts 0→11.
  - Round 11 cycle: `xor_key_end_o`=1, then DONE.
- **DONE:**
  - `tag_valid_o`=1, `done_o`=1 and `busy_o`=1 for 1 cycle, then IDLE.
- **Round counter:**
  - 4-bit unsigned.
  - Increments only while `perm_en_o`=1.
  - Terminal value is 11; it never wraps past 11 and never reaches 12..15.
- `round_o` = counter when `perm_en_o`=1, and 0 otherwise.
- All outputs are Moore outputs from state/counter, except the handshake-qualified strobes: `xor_data_o`, `cipher_valid_o` and `xor_key_begin_o`.

## Timing
- `start_i` at cycle 0:
  - LOAD at cycle 1.
  - INIT at cycles 2–13.
  - WAIT_AD or WAIT_PT at cycle 14, where `blk_ready_o`=1.
- Each non-final block costs 6 perm cycles plus at least 1 wait cycle.
- Last PT handshake at cycle t:
  - FINAL at cycles t+1..t+12.
  - DONE at cycle t+13.
- `start_i` while `busy_o`=1 is ignored.
- `blk_valid_i` outside the WAIT states has no effect; the block stays pending upstream.
- `resetb_i` low in any state returns asynchronously to IDLE, with all outputs 0 in the same cycle. There is no partial completion and no `done_o`.

## Configuration
- `ASCON_AD_EN` defined:
  - AD phase supported.
  - `ad_en_i` latched as described in Operation.
- `ASCON_AD_EN` undefined:
  - WAIT_AD and PERM_AD are not implemented.
  - `ad_en_i` is ignored and the ad flag is forced to 0.
  - INIT always exits to WAIT_PT with `xor_dom_sep_o`=1 on round 11.

## Test plan
- **Reset:** assert `resetb_i`=0 → all outputs are 0 and `busy_o`=0. Release and idle for 5 cycles → outputs stay 0.
- **No-AD, one PT block:** `start_i` with `ad_en_i`=0; one block with `blk_last_i`=1 at the first ready.
  - `load_o` at cycle 1.
  - `round_o` 0..11 at cycles 2–13, with `xor_key_end_o` and `xor_dom_sep_o` at cycle 13.
  - `cipher_valid_o` and `xor_key_begin_o` at cycle 14.
  - FINAL rounds 0..11 at cycles 15–26.
  - `tag_valid_o` and `done_o` at cycle 27.
- **AD case, `ASCON_AD_EN`:** 2 AD blocks then 2 PT blocks, valid always high.
  - Each AD block gives `round_o` 6..11.
  - `xor_dom_sep_o` appears only after the second AD block.
  - `cipher_valid_o` pulses exactly twice; `done_o` pulses once.
- **Backpressure:** hold `blk_valid_i`=0 for 10 cycles in WAIT_PT → `blk_ready_o` stays 1 and `perm_en_o` stays 0. Raise it → handshake happens in that same cycle.
- **Reset mid-FINAL:** pull `resetb_i` low at round 5 → immediate IDLE, no `tag_valid_o`. A new start repeats the full 27-cycle sequence.
- **`start_i` during INIT:** ignored; round sequence unchanged and `done_o` pulses once.
